// File: rtl/adder_share_arbiter.sv
// ============================================================================
// Module   : adder_share_arbiter (with ripple_carry_adder10)
// Brief    : Round-robin sharing of one ripple-carry adder among R requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_carry_adder10 #(
    parameter int n = 10
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    logic [n:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar i = 0; i < n; i++) begin : g_bit
            assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_carry[n];

endmodule

module adder_share_arbiter #(
    parameter int  N   = 32,
    parameter int  R   = 4,
    localparam int IDW = (R > 1) ? $clog2(R) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_a,
    input  logic [R*N-1:0] req_b,
    input  logic [R-1:0]   req_cin,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N-1:0]   rsp_sum,
    output logic           rsp_cout,
    output logic [IDW-1:0] rsp_id
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_op_id;
    logic [N-1:0]   r_op_a;
    logic [N-1:0]   r_op_b;
    logic           r_op_cin;

    logic           w_found;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_ptr_next;
    int             w_idx;
    logic [N-1:0]   w_sum;
    logic           w_cout;

    // Scan from the pointer upward, wrapping explicitly so non-power-of-2 R works
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < R; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= R) begin
                w_idx = w_idx - R;
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        if (w_win == IDW'(R - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_win + IDW'(1);
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_found) begin
            req_ready[w_win] = 1'b1;
        end
    end

    ripple_carry_adder10 #(
        .n (N)
    ) u_adder (
        .a    (r_op_a),
        .b    (r_op_b),
        .cin  (r_op_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_op_id   <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_cin  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op_a   <= req_a[w_win*N +: N];
                        r_op_b   <= req_b[w_win*N +: N];
                        r_op_cin <= req_cin[w_win];
                        r_op_id  <= w_win;
                        r_ptr    <= w_ptr_next;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    rsp_sum   <= w_sum;
                    rsp_cout  <= w_cout;
                    rsp_id    <= r_op_id;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
